add_arbiter: RTL and testbench
==============================

ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 The block SHALL use one parameter: CNT_W, default 8, width of the completed-operation counter.
REQ-002 The block SHALL have these ports, one clock, asynchronous active-low reset:
 clk  input  1  rising-edge clock
 rst_n  input  1  asynchronous active-low reset
 req0_valid  input  1  requester 0 has operands
 req0_a  input  16  requester 0 operand A
 req0_b  input  16  requester 0 operand B
 req0_ready  output  1  requester 0 operands accepted this cycle
 req1_valid  input  1  requester 1 has operands
 req1_a  input  16  requester 1 operand A
 req1_b  input  16  requester 1 operand B
 req1_ready  output  1  requester 1 operands accepted this cycle
 rsp_valid  output  1  result register holds a result
 rsp_id  output  1  requester that owns the result
 rsp_sum  output  17  unsigned sum, bit 16 = carry out
 rsp_ready  input  1  consumer takes result this cycle
 op_count  output  CNT_W  completed (consumed) operations, saturating

Function
REQ-003 The block SHALL instantiate exactly one 16-bit adder (adder16, carry-in 0, 17-bit sum) shared by both requesters via an operand mux.
REQ-004 The block SHALL use a two-state FSM: EMPTY (no result held) and FULL (result held, rsp_valid=1).
REQ-005 An accept SHALL occur when a granted reqN_valid=1 and (state=EMPTY or rsp_ready=1 in FULL); reqN_ready SHALL be asserted only for the granted requester under that condition.
REQ-006 reqN_ready SHALL be combinational from valids, state, rsp_ready and priority pointer; at most one reqN_ready SHALL be high per cycle.
REQ-007 Arbitration SHALL be round-robin: a 1-bit priority pointer selects the preferred requester; if only one requester is valid it SHALL be granted regardless of the pointer.
REQ-008 After an accept from requester i, the pointer SHALL point to the other requester on the next cycle; without an accept the pointer SHALL hold.
REQ-009 On accept, rsp_sum SHALL load A+B of the granted requester (full 17 bits, no truncation) and rsp_id SHALL load i at the same clock edge; latency accept-to-rsp_valid SHALL be 1 cycle.
REQ-010 Transitions: EMPTY+accept -> FULL; FULL+rsp_ready+accept -> FULL with new result (back-to-back, no bubble); FULL+rsp_ready+no accept -> EMPTY; FULL+!rsp_ready -> FULL with rsp_sum/rsp_id held stable.
REQ-011 rsp_sum and rsp_id SHALL not change while rsp_valid=1 and rsp_ready=0.
REQ-012 op_count SHALL increment by 1 on each cycle with rsp_valid=1 and rsp_ready=1, and SHALL saturate at 2^CNT_W-1 (no wrap).
REQ-013 rsp_ready asserted while EMPTY SHALL have no effect.
REQ-014 Operand values on non-accepted cycles SHALL not affect any register.

Reset
REQ-015 When rst_n=0, asynchronously: state=EMPTY, rsp_valid=0, rsp_id=0, rsp_sum=0, pointer=0 (requester 0 preferred), op_count=0.
REQ-016 Reset asserted mid-operation SHALL discard any held result without producing a handshake; reqN_ready SHALL be 0 while rst_n=0.
REQ-017 First accept after reset deassertion SHALL be possible on the first rising edge with rst_n=1.

Verification
REQ-018 Single request: req0 A=0x0003 B=0x0004 from EMPTY, rsp_ready=1 -> req0_ready=1 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_sum=0x00007; op_count=1 after consumption.
REQ-019 Carry: req1 A=0xFFFF B=0x0001 -> rsp_sum=0x10000, rsp_id=1; A=0xFFFF B=0xFFFF -> rsp_sum=0x1FFFE.
REQ-020 Contention: both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 with one result per cycle, no bubbles, rsp_id matching.
REQ-021 Backpressure: result held with rsp_ready=0 for 5 cycles while both valid -> both reqN_ready=0, rsp_sum/rsp_id stable; on rsp_ready=1 the next grant occurs same cycle.
REQ-022 Saturation: CNT_W=2, 5 consumed results -> op_count sequence 1,2,3,3,3.
REQ-023 Reset mid-hold: rst_n pulsed low while rsp_valid=1 -> rsp_valid=0, op_count=0 immediately; with both valid afterwards, first grant goes to requester 0.

Source files
------------

// File: rtl/add_arbiter.sv
// Two-requester round-robin front end sharing a single 16-bit adder.
// One result register with valid/ready output handshake and a saturating completion counter.

module adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [16:0] sum
);
    assign sum = {1'b0, a} + {1'b0, b};
endmodule

module add_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [16:0]      rsp_sum,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    state_t      state_next;
    logic        ptr;
    logic        grant;
    logic        accept;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [16:0] sum_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // rst_n gates accept so no requester sees ready while held in reset.
    assign accept     = rst_n && (req0_valid || req1_valid) && ((state == EMPTY) || rsp_ready);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign op_a = grant ? req1_a : req0_a;
    assign op_b = grant ? req1_b : req0_b;

    adder16 u_adder (
        .a   (op_a),
        .b   (op_b),
        .sum (sum_p0)
    );

    always_comb begin
        state_next = state;
        case (state)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (rsp_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign rsp_valid = (state == FULL);

    // Result stage: loads only on accept, so operands are ignored otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            ptr      <= 1'b0;
            rsp_id   <= 1'b0;
            rsp_sum  <= '0;
            op_count <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                rsp_sum <= sum_p0;
                rsp_id  <= grant;
                ptr     <= ~grant;
            end
            if (rsp_valid && rsp_ready) begin
                op_count <= sat_inc(op_count);
            end
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: directed vector table, reset sequences and a randomized run
// checked against a transaction-level model (default width plus a CNT_W=2 instance).

module tb_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id;
    logic [16:0] rsp_sum;
    logic [7:0]  op_count;
    logic        d2_req0_ready, d2_req1_ready, d2_rsp_valid, d2_rsp_id;
    logic [16:0] d2_rsp_sum;
    logic [1:0]  d2_op_count;

    always #5 clk = ~clk;

    add_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
        .op_count(op_count)
    );

    add_arbiter #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(d2_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(d2_req1_ready),
        .rsp_valid(d2_rsp_valid), .rsp_id(d2_rsp_id), .rsp_sum(d2_rsp_sum), .rsp_ready(rsp_ready),
        .op_count(d2_op_count)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: one optional held result, a preferred requester, a count.
    bit m_has, m_id, m_ptr;
    int m_sum, m_cnt;
    bit seen_r0, seen_r1;

    typedef struct {
        bit          v0;
        logic [15:0] a0, b0;
        bit          v1;
        logic [15:0] a1, b1;
        bit          rr;
        bit          r0, r1;
        bit          rv;
        bit          id;
        int          sum;
        int          cnt;
    } vec_t;

    vec_t tbl[18];

    function automatic int sat(input int c, input int w);
        int lim;
        lim = (1 << w) - 1;
        return (c > lim) ? lim : c;
    endfunction

    function automatic vec_t mk(input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                                input bit v1, input logic [15:0] a1, input logic [15:0] b1,
                                input bit rr, input bit r0, input bit r1, input bit rv,
                                input bit id, input int sum, input int cnt);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rr = rr;
        v.r0 = r0; v.r1 = r1; v.rv = rv; v.id = id; v.sum = sum; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_has = 0; m_id = 0; m_ptr = 0; m_sum = 0; m_cnt = 0;
    endtask

    task automatic cycle(input bit v0, input logic [15:0] a0, input logic [15:0] b0,
                         input bit v1, input logic [15:0] a1, input logic [15:0] b1,
                         input bit rr);
        bit g, acc;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        g   = (v0 && v1) ? m_ptr : v1;
        acc = (v0 || v1) && (!m_has || rr);
        @(negedge clk);
        seen_r0 = req0_ready;
        seen_r1 = req1_ready;
        check("req0_ready", {31'd0, req0_ready}, {31'd0, acc && !g});
        check("req1_ready", {31'd0, req1_ready}, {31'd0, acc && g});
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_has});
        check("rsp_id", {31'd0, rsp_id}, {31'd0, m_id});
        check("rsp_sum", {15'd0, rsp_sum}, m_sum);
        check("op_count", {24'd0, op_count}, sat(m_cnt, 8));
        check("op_count_w2", {30'd0, d2_op_count}, sat(m_cnt, 2));
        check("dut2_rsp", {12'd0, d2_req0_ready, d2_req1_ready, d2_rsp_valid, d2_rsp_id, d2_rsp_sum},
              {12'd0, acc && !g, acc && g, m_has, m_id, m_sum[16:0]});
        @(posedge clk);
        if (m_has && rr) m_cnt++;
        if (acc) begin
            m_has = 1;
            m_id  = g;
            m_sum = (g ? (int'(a1) + int'(b1)) : (int'(a0) + int'(b0)));
            m_ptr = !g;
        end else if (m_has && rr) begin
            m_has = 0;
        end
        #1;
    endtask

    initial begin
        // Hand-derived sequence starting from reset (EMPTY, pointer at requester 0).
        tbl[0]  = mk(1, 16'h0003, 16'h0004, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, 0, 'h00007, 0);
        tbl[1]  = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 'h00007, 1);
        tbl[2]  = mk(0, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'h0001, 0, 0, 1, 1, 1, 'h10000, 1);
        tbl[3]  = mk(0, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'hFFFF, 0, 0, 0, 1, 1, 'h10000, 1);
        tbl[4]  = mk(0, 16'h0000, 16'h0000, 1, 16'hFFFF, 16'hFFFF, 1, 0, 1, 1, 1, 'h1FFFE, 2);
        tbl[5]  = mk(1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002, 1, 1, 0, 1, 0, 'h00002, 3);
        tbl[6]  = mk(1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002, 1, 0, 1, 1, 1, 'h00004, 4);
        tbl[7]  = mk(1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002, 1, 1, 0, 1, 0, 'h00002, 5);
        tbl[8]  = mk(1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002, 1, 0, 1, 1, 1, 'h00004, 6);
        for (int i = 9; i < 14; i++)
            tbl[i] = mk(1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002, 0, 0, 0, 1, 1, 'h00004, 6);
        tbl[14] = mk(1, 16'h0001, 16'h0001, 1, 16'h0002, 16'h0002, 1, 1, 0, 1, 0, 'h00002, 7);
        tbl[15] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 'h00002, 8);
        tbl[16] = mk(0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 0, 0, 0, 'h00002, 8);
        tbl[17] = mk(1, 16'h1234, 16'h4321, 0, 16'h0000, 16'h0000, 0, 1, 0, 1, 0, 'h05555, 8);

        // Reset with both requesters valid: no ready may escape, registers at reset values.
        rst_n = 1'b0;
        req0_valid = 1; req0_a = 16'h1111; req0_b = 16'h2222;
        req1_valid = 1; req1_a = 16'h3333; req1_b = 16'h4444;
        rsp_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {30'd0, req0_ready, req1_ready}, 0);
        check("reset_rsp", {14'd0, rsp_valid, rsp_id, rsp_sum}, 0);
        check("reset_count", {22'd0, op_count, d2_op_count}, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].v0, tbl[i].a0, tbl[i].b0, tbl[i].v1, tbl[i].a1, tbl[i].b1, tbl[i].rr);
            check($sformatf("vec%0d_ready", i), {30'd0, seen_r0, seen_r1}, {30'd0, tbl[i].r0, tbl[i].r1});
            check($sformatf("vec%0d_rsp", i), {13'd0, rsp_valid, rsp_id, rsp_sum},
                  {13'd0, tbl[i].rv, tbl[i].id, tbl[i].sum[16:0]});
            check($sformatf("vec%0d_count", i), {24'd0, op_count}, tbl[i].cnt);
            check($sformatf("vec%0d_count_w2", i), {30'd0, d2_op_count}, sat(tbl[i].cnt, 2));
        end

        // Reset while a result is held (pointer currently at requester 1).
        req0_valid = 1; req1_valid = 1; rsp_ready = 0;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, rsp_valid}, 0);
        check("midrst_count", {22'd0, op_count, d2_op_count}, 0);
        check("midrst_ready", {30'd0, req0_ready, req1_ready}, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cycle(1, 16'h0010, 16'h0020, 1, 16'h0100, 16'h0200, 1);
        check("postrst_first_grant", {31'd0, seen_r0}, 1);
        check("postrst_rsp", {14'd0, rsp_valid, rsp_id, rsp_sum}, {14'd0, 1'b1, 1'b0, 17'h00030});
        cycle(1, 16'h0010, 16'h0020, 1, 16'h0100, 16'h0200, 1);
        check("postrst_second_grant", {31'd0, seen_r1}, 1);

        // Randomized traffic against the model, including enough consumes to saturate.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 3) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
